// File: rtl/lfsr_pkg.sv
// lfsr_pkg: definitions shared by the LFSR pattern generator and the LFSR checker.
//   - FSM state encoding for the checker: SEED, VERIFY and LOCKED.
//   - TAPS_DFLT: the default feedback mask, x^4+x^3+1, which gives period 15.
//   - lfsr_fb(): the feedback function. The generator and the checker both call it,
//     so the two ends of the link cannot disagree on the polynomial.
package lfsr_pkg;

  localparam logic [1:0] ST_SEED   = 2'd0;
  localparam logic [1:0] ST_VERIFY = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  // Mask over s[1:WIDTH]. The MSB of the literal lines up with s[1].
  localparam logic [3:0] TAPS_DFLT = 4'b1001;

  // Callers zero-extend s[1:WIDTH] and the tap mask to 32 bits. Both are
  // right-aligned, so s[WIDTH] always lines up with taps[WIDTH].
  function automatic logic lfsr_fb(input logic [31:0] s, input logic [31:0] taps);
    return ^(s & taps);
  endfunction

endpackage

// File: rtl/lfsr_checker_sat_counter.sv
// sat_counter: saturating event counter with a synchronous clear.
//   clk_i  in   clock, rising edge
//   rst_i  in   synchronous active-high reset; the count goes to 0
//   inc_i  in   count one event
//   clr_i  in   clear the count. If clr_i and inc_i arrive together, the count
//               becomes 1, so the coincident event is kept.
//   cnt_o  out  current count; it holds at all-ones and never wraps
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                      cnt_d = inc_i ? W'(1) : '0;
    else if (inc_i && cnt_q != '1)  cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/lfsr_checker.sv
// lfsr_checker: receive-side partner of the LFSR pattern generator.
//   It seeds itself from the incoming serial stream, locks onto the sequence,
//   and then counts the bit errors it sees while locked.
//   CLK        in   clock, rising edge
//   RST        in   synchronous active-high reset
//   in_valid   in   sample in_bit on this edge. When low, all state holds.
//   in_bit     in   received stream bit
//   err_clr    in   synchronous clear of err_count
//   locked     out  registered lock indicator
//   err_pulse  out  one-cycle pulse for each mismatch seen while locked
//   err_count  out  saturating count of mismatches seen while locked
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int unsigned    WIDTH     = 4,
  parameter logic [1:WIDTH] TAPS      = TAPS_DFLT,
  parameter int unsigned    LOCK_CNT  = 8,
  parameter int unsigned    LOSS_ERRS = 4,
  parameter int unsigned    CNT_W     = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             err_clr,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count
);

  localparam int unsigned SW = $clog2(WIDTH);
  localparam int unsigned RW = $clog2(LOCK_CNT + 1);
  localparam int unsigned MW = $clog2(LOSS_ERRS + 1);
  localparam logic [SW-1:0] SEED_LAST = SW'(WIDTH - 1);
  localparam logic [RW-1:0] RUN_MAX   = RW'(LOCK_CNT);
  localparam logic [MW-1:0] MISS_MAX  = MW'(LOSS_ERRS);

  logic [1:0]       state_q, state_d;
  logic [1:WIDTH]   s_q, s_d;
  logic [SW-1:0]    seed_cnt_q, seed_cnt_d;
  logic [RW-1:0]    run_cnt_q, run_cnt_d;
  logic [MW-1:0]    miss_cnt_q, miss_cnt_d;
  logic             locked_q, err_pulse_q;
  logic             pred, err_hit;

  assign pred = lfsr_fb(32'(s_q), 32'(TAPS));

  always_comb begin
    state_d    = state_q;
    s_d        = s_q;
    seed_cnt_d = seed_cnt_q;
    run_cnt_d  = run_cnt_q;
    miss_cnt_d = miss_cnt_q;
    err_hit    = 1'b0;
    if (in_valid) begin
      case (state_q)
        ST_SEED: begin
          s_d = {in_bit, s_q[1:WIDTH-1]};
          if (seed_cnt_q == SEED_LAST) begin
            seed_cnt_d = '0;
            // An all-zero register would lock the LFSR up for good, so
            // reject it and start collecting a new seed.
            if (s_d != '0) begin
              state_d   = ST_VERIFY;
              run_cnt_d = '0;
            end
          end else begin
            seed_cnt_d = seed_cnt_q + SW'(1);
          end
        end
        ST_VERIFY: begin
          if (in_bit == pred) begin
            s_d       = {pred, s_q[1:WIDTH-1]};
            run_cnt_d = run_cnt_q + RW'(1);
            if (run_cnt_d == RUN_MAX) begin
              state_d    = ST_LOCKED;
              miss_cnt_d = '0;
            end
          end else begin
            // The seed was probably corrupted, so start again from scratch.
            state_d    = ST_SEED;
            seed_cnt_d = '0;
            s_d        = '0;
          end
        end
        ST_LOCKED: begin
          // The register always follows its own prediction, so a received
          // error never enters s and cannot propagate.
          s_d = {pred, s_q[1:WIDTH-1]};
          if (in_bit == pred) begin
            if (run_cnt_q != RUN_MAX) run_cnt_d = run_cnt_q + RW'(1);
            if (run_cnt_d == RUN_MAX) miss_cnt_d = '0;
          end else begin
            err_hit    = 1'b1;
            run_cnt_d  = '0;
            miss_cnt_d = miss_cnt_q + MW'(1);
            if (miss_cnt_d == MISS_MAX) begin
              state_d    = ST_SEED;
              seed_cnt_d = '0;
              s_d        = '0;
            end
          end
        end
        default: begin
          state_d    = ST_SEED;
          seed_cnt_d = '0;
          s_d        = '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_SEED;
      s_q         <= '0;
      seed_cnt_q  <= '0;
      run_cnt_q   <= '0;
      miss_cnt_q  <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      seed_cnt_q  <= seed_cnt_d;
      run_cnt_q   <= run_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      locked_q    <= (state_d == ST_LOCKED);
      err_pulse_q <= err_hit;
    end
  end

  sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk_i (CLK),
    .rst_i (RST),
    .inc_i (err_hit),
    .clr_i (err_clr),
    .cnt_o (err_count)
  );

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;

endmodule
